// File: rtl/plru_ctrl.sv
// Tree pseudo-LRU replacement controller for one set-associative cache. It performs a 2-stage
// read-modify-write of the PLRU bits in a dual-port array and zeroes the array on reset/flush.
module plru_ctrl #(
   parameter int unsigned S_INDEX = 4,
   parameter int unsigned WAYS    = 4,
   localparam int unsigned W      = WAYS - 1,
   localparam int unsigned WW     = $clog2(WAYS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_req_i,
   output logic               flush_busy_o,
   input  logic               touch_valid_i,
   output logic               touch_ready_o,
   input  logic [S_INDEX-1:0] touch_set_i,
   input  logic [WW-1:0]      touch_way_i,
   input  logic               alloc_valid_i,
   output logic               alloc_ready_o,
   input  logic [S_INDEX-1:0] alloc_set_i,
   output logic               victim_valid_o,
   output logic [WW-1:0]      victim_way_o,
   output logic               lru_csb0_o,
   output logic               lru_web0_o,
   output logic [S_INDEX-1:0] lru_addr0_o,
   input  logic [W-1:0]       lru_dout0_i,
   output logic               lru_csb1_o,
   output logic               lru_web1_o,
   output logic [S_INDEX-1:0] lru_addr1_o,
   output logic [W-1:0]       lru_din1_o
);

   typedef enum logic [0:0] {StFlush, StRun} state_e;

   state_e               state_q, state_d;
   logic [S_INDEX-1:0]   cnt_q, cnt_d;
   logic                 s1_valid_q, s1_alloc_q;
   logic [S_INDEX-1:0]   s1_set_q;
   logic [WW-1:0]        s1_way_q;

   logic                 run_en, alloc_acc, touch_acc, s0_fire;
   logic [S_INDEX-1:0]   s0_set;
   logic [WW-1:0]        victim_c, access_way;
   logic [W-1:0]         new_bits;

   // Walk from the root: a 0 bit points into the lower subtree, a 1 bit into the upper one.
   function automatic logic [WW-1:0] plru_victim(input logic [W-1:0] bits);
      logic [WW-1:0] way;
      logic          b;
      int            node;
      way  = '0;
      node = 0;
      for (int l = 0; l < int'(WW); l++) begin
         b = 1'b0;
         for (int i = 0; i < int'(W); i++) begin
            if (i == node) b = bits[i];
         end
         way[int'(WW) - 1 - l] = b;
         node = 2 * node + 1 + int'(b);
      end
      return way;
   endfunction

   function automatic logic [W-1:0] plru_update(input logic [W-1:0]  bits,
                                                input logic [WW-1:0] way);
      logic [W-1:0] nb;
      logic         dir;
      int           node;
      nb   = bits;
      node = 0;
      for (int l = 0; l < int'(WW); l++) begin
         dir = way[int'(WW) - 1 - l];
         for (int i = 0; i < int'(W); i++) begin
            if (i == node) nb[i] = ~dir;
         end
         node = 2 * node + 1 + int'(dir);
      end
      return nb;
   endfunction

   assign run_en    = rst_ni && (state_q == StRun) && !flush_req_i;
   assign alloc_acc = alloc_valid_i && run_en;
   assign touch_acc = touch_valid_i && run_en && !alloc_valid_i;
   assign s0_fire   = alloc_acc || touch_acc;
   assign s0_set    = alloc_acc ? alloc_set_i : touch_set_i;

   // Read data already carries any same-cycle port1 write, forwarded by the array.
   assign victim_c   = plru_victim(lru_dout0_i);
   assign access_way = s1_alloc_q ? victim_c : s1_way_q;
   assign new_bits   = plru_update(lru_dout0_i, access_way);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StFlush;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_alloc_q <= 1'b0;
         s1_set_q   <= '0;
         s1_way_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s0_fire;
         s1_alloc_q <= alloc_acc;
         s1_set_q   <= s0_set;
         s1_way_q   <= touch_way_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StFlush: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = StRun;
         end
         StRun: begin
            if (flush_req_i) begin
               state_d = StFlush;
               cnt_d   = '0;
            end
         end
         default: state_d = StFlush;
      endcase
   end

   always_comb begin
      flush_busy_o   = !rst_ni || (state_q == StFlush);
      alloc_ready_o  = run_en;
      touch_ready_o  = run_en && !alloc_valid_i;
      lru_csb0_o     = !s0_fire;
      lru_web0_o     = 1'b1;
      lru_addr0_o    = s0_set;
      lru_csb1_o     = 1'b1;
      lru_web1_o     = 1'b1;
      lru_addr1_o    = s1_set_q;
      lru_din1_o     = new_bits;
      victim_valid_o = 1'b0;
      victim_way_o   = victim_c;
      if (rst_ni) begin
         if (state_q == StFlush) begin
            lru_csb1_o  = 1'b0;
            lru_web1_o  = 1'b0;
            lru_addr1_o = cnt_q;
            lru_din1_o  = '0;
         end else if (s1_valid_q) begin
            lru_csb1_o     = 1'b0;
            lru_web1_o     = 1'b0;
            victim_valid_o = s1_alloc_q;
         end
      end
   end

endmodule
